// File: rtl/wt_dcache_load_req.sv
// Load-side request initiator for the write-through dcache read port.
// Turns a valid/ready load stream into index/tag request phases. It can kill an
// outstanding load on flush and returns one result per surviving load.
module wt_dcache_load_req #(
    parameter int unsigned PLEN          = 56,
    parameter int unsigned XLEN          = 64,
    parameter int unsigned IdxWidth      = 12,
    parameter int unsigned TagWidth      = PLEN - IdxWidth,
    parameter int unsigned IdWidth       = 2,
    parameter int unsigned UserWidth     = 1,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 op_valid_i,
    output logic                 op_ready_o,
    input  logic [PLEN-1:0]      op_paddr_i,
    input  logic [1:0]           op_size_i,
    input  logic [IdWidth-1:0]   op_id_i,
    output logic                 res_valid_o,
    output logic [XLEN-1:0]      res_data_o,
    output logic [UserWidth-1:0] res_user_o,
    output logic [IdWidth-1:0]   res_id_o,
    output logic                 err_o,
    output logic                 data_req_o,
    input  logic                 data_gnt_i,
    output logic [IdxWidth-1:0]  address_index_o,
    output logic [TagWidth-1:0]  address_tag_o,
    output logic                 tag_valid_o,
    output logic                 kill_req_o,
    output logic [1:0]           data_size_o,
    output logic [IdWidth-1:0]   data_id_o,
    output logic                 data_we_o,
    input  logic                 data_rvalid_i,
    input  logic [IdWidth-1:0]   data_rid_i,
    input  logic [XLEN-1:0]      data_rdata_i,
    input  logic [UserWidth-1:0] data_ruser_i
);

    localparam int unsigned CntWidth = $clog2(TimeoutCycles);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        KILL = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [TagWidth-1:0]   tag_q;
    logic [IdWidth-1:0]    id_q;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  grant;

    // Index phase and request attributes come straight from the load unit
    assign address_index_o = op_paddr_i[IdxWidth-1:0];
    assign data_size_o     = op_size_i;
    assign data_id_o       = op_id_i;
    assign data_we_o       = 1'b0;
    assign address_tag_o   = tag_q;
    assign err_o           = err_q;
    assign grant           = op_ready_o;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: flush beats response, response with grant keeps us pending
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant) state_d = PEND;
            end
            PEND: begin
                if (flush_i) begin
                    state_d = data_rvalid_i ? IDLE : KILL;
                end else if (data_rvalid_i) begin
                    state_d = grant ? PEND : IDLE;
                end
            end
            KILL: begin
                if (data_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: request gating, tag/kill phases and the unbuffered result pulse
    always_comb begin
        logic req;
        req         = op_valid_i & ~flush_i & ((state_q == IDLE) | (state_q == PEND));
        data_req_o  = req;
        op_ready_o  = req & data_gnt_i;
        tag_valid_o = (state_q == PEND);
        kill_req_o  = ((state_q == PEND) & flush_i) | (state_q == KILL);
        res_valid_o = (state_q == PEND) & ~flush_i & data_rvalid_i;
        res_data_o  = res_valid_o ? data_rdata_i : '0;
        res_user_o  = res_valid_o ? data_ruser_i : '0;
        res_id_o    = res_valid_o ? id_q : '0;
    end

    // Watchdog counter and sticky protocol error detection
    always_comb begin
        cnt_d = cnt_q;
        if (grant || ((state_q == PEND) && flush_i)) begin
            cnt_d = '0;
        end else if ((state_q != IDLE) && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntWidth'(1);
        end

        err_d = err_q;
        if (data_rvalid_i && (state_q == IDLE)) err_d = 1'b1;
        if ((state_q == PEND) && !flush_i && data_rvalid_i && (data_rid_i != id_q)) err_d = 1'b1;
        if ((state_q == PEND) && grant && !data_rvalid_i) err_d = 1'b1;
        if ((state_q != IDLE) && (cnt_d == CntMax)) err_d = 1'b1;
    end

    // Outstanding-load tag/ID capture, watchdog and error registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q <= '0;
            id_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (grant) begin
                tag_q <= op_paddr_i[PLEN-1:IdxWidth];
                id_q  <= op_id_i;
            end
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_wt_dcache_load_req.sv
// Self-checking bench for wt_dcache_load_req: transaction-level model of the
// single outstanding load plus a result scoreboard consumed by a separate monitor.
module tb_wt_dcache_load_req;

    localparam int unsigned PLEN = 56;
    localparam int unsigned XLEN = 64;
    localparam int unsigned IW   = 12;
    localparam int unsigned TW   = PLEN - IW;
    localparam int unsigned IDW  = 2;
    localparam int unsigned UW   = 1;
    localparam int unsigned TO   = 48;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            flush_i, op_valid_i, op_ready_o;
    logic [PLEN-1:0] op_paddr_i;
    logic [1:0]      op_size_i;
    logic [IDW-1:0]  op_id_i;
    logic            res_valid_o;
    logic [XLEN-1:0] res_data_o;
    logic [UW-1:0]   res_user_o;
    logic [IDW-1:0]  res_id_o;
    logic            err_o, data_req_o, data_gnt_i;
    logic [IW-1:0]   address_index_o;
    logic [TW-1:0]   address_tag_o;
    logic            tag_valid_o, kill_req_o;
    logic [1:0]      data_size_o;
    logic [IDW-1:0]  data_id_o;
    logic            data_we_o, data_rvalid_i;
    logic [IDW-1:0]  data_rid_i;
    logic [XLEN-1:0] data_rdata_i;
    logic [UW-1:0]   data_ruser_i;

    wt_dcache_load_req #(
        .PLEN(PLEN), .XLEN(XLEN), .IdxWidth(IW), .TagWidth(TW),
        .IdWidth(IDW), .UserWidth(UW), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_paddr_i(op_paddr_i),
        .op_size_i(op_size_i), .op_id_i(op_id_i),
        .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_user_o(res_user_o),
        .res_id_o(res_id_o), .err_o(err_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
        .address_index_o(address_index_o), .address_tag_o(address_tag_o),
        .tag_valid_o(tag_valid_o), .kill_req_o(kill_req_o),
        .data_size_o(data_size_o), .data_id_o(data_id_o), .data_we_o(data_we_o),
        .data_rvalid_i(data_rvalid_i), .data_rid_i(data_rid_i),
        .data_rdata_i(data_rdata_i), .data_ruser_i(data_ruser_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] data;
        logic [UW-1:0]   user;
        logic [IDW-1:0]  id;
    } res_t;

    res_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: at most one outstanding load, alive or killed
    bit            m_alive, m_killed, m_err;
    logic [IDW-1:0] m_id;
    logic [TW-1:0]  m_tag;
    int            m_wd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Result monitor: every pulse must match the oldest expected response
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            #2;
            if (res_valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL res_unexpected actual_id=%0d required=no_pulse at %0t", res_id_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_data", res_data_o, e.data);
                    chk("res_user", 64'(res_user_o), 64'(e.user));
                    chk("res_id", 64'(res_id_o), 64'(e.id));
                end
            end
        end
    end

    // One clock cycle: drive, check combinational/registered outputs, advance model
    task automatic cyc(input bit fl, input bit opv, input logic [PLEN-1:0] pa,
                       input logic [1:0] sz, input logic [IDW-1:0] id, input bit gnt,
                       input bit rv, input logic [IDW-1:0] rid,
                       input logic [XLEN-1:0] rd, input logic [UW-1:0] ru);
        bit   req_e, gnt_e, was_out;
        res_t r;
        flush_i = fl; op_valid_i = opv; op_paddr_i = pa; op_size_i = sz; op_id_i = id;
        data_gnt_i = gnt; data_rvalid_i = rv; data_rid_i = rid;
        data_rdata_i = rd; data_ruser_i = ru;
        #1;
        req_e = opv && !fl && !m_killed;
        gnt_e = req_e && gnt;
        chk("data_req", 64'(data_req_o), 64'(req_e));
        chk("op_ready", 64'(op_ready_o), 64'(gnt_e));
        chk("tag_valid", 64'(tag_valid_o), 64'(m_alive));
        chk("address_tag", 64'(address_tag_o), 64'(m_tag));
        chk("kill_req", 64'(kill_req_o), 64'(m_killed || (m_alive && fl)));
        chk("address_index", 64'(address_index_o), 64'(pa[IW-1:0]));
        chk("data_size", 64'(data_size_o), 64'(sz));
        chk("data_id", 64'(data_id_o), 64'(id));
        chk("data_we", 64'(data_we_o), 64'd0);
        chk("err", 64'(err_o), 64'(m_err));

        was_out = m_alive || m_killed;
        if (rv && !was_out) m_err = 1'b1;
        if (m_alive && rv && !fl && rid != m_id) m_err = 1'b1;
        if (m_alive && gnt_e && !rv) m_err = 1'b1;
        if (m_alive && fl) begin
            m_alive  = 1'b0;
            m_killed = !rv;
            m_wd     = 0;
        end else begin
            if (m_alive && rv) begin
                r.data = rd; r.user = ru; r.id = m_id;
                exp_q.push_back(r);
                m_alive = 1'b0;
            end else if (m_killed && rv) begin
                m_killed = 1'b0;
            end
            if (was_out && m_wd < int'(TO) - 1) m_wd++;
        end
        if (gnt_e) begin
            m_alive = 1'b1;
            m_id    = id;
            m_tag   = pa[PLEN-1:IW];
            m_wd    = 0;
        end else if (was_out && m_wd == int'(TO) - 1) begin
            m_err = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle_cyc();
        cyc(0, 0, '0, 2'd0, '0, 0, 0, '0, '0, '0);
    endtask

    // Asynchronous reset taken mid-cycle; outputs must clear immediately
    task automatic do_reset();
        flush_i = 0; op_valid_i = 0; op_paddr_i = '0; op_size_i = '0; op_id_i = '0;
        data_gnt_i = 0; data_rvalid_i = 0; data_rid_i = '0; data_rdata_i = '0; data_ruser_i = '0;
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_res_valid", 64'(res_valid_o), 64'd0);
        chk("rst_res_data", res_data_o, 64'd0);
        chk("rst_res_id", 64'(res_id_o), 64'd0);
        chk("rst_tag_valid", 64'(tag_valid_o), 64'd0);
        chk("rst_kill_req", 64'(kill_req_o), 64'd0);
        chk("rst_data_req", 64'(data_req_o), 64'd0);
        chk("rst_op_ready", 64'(op_ready_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_address_tag", 64'(address_tag_o), 64'd0);
        m_alive = 0; m_killed = 0; m_err = 0; m_wd = 0; m_tag = '0; m_id = '0;
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [PLEN-1:0] pa;
        logic [XLEN-1:0] rd;
        bit fl, opv, gnt, rv;
        logic [IDW-1:0] rid;

        rst_ni = 1'b0;
        @(negedge clk);
        do_reset();

        // Single hit: grant then response one cycle later
        cyc(0, 1, 56'h8000_1238, 2'd3, 2'd1, 1, 0, '0, '0, '0);
        chk("hit_tag_literal", 64'(address_tag_o), 64'h80001);
        cyc(0, 0, '0, 2'd0, '0, 0, 1, 2'd1, 64'hDEADBEEF_0BADF00D, 1'b1);
        idle_cyc();

        // Back-to-back: second grant lands in the first response cycle
        cyc(0, 1, 56'h12_3456_7000, 2'd2, 2'd1, 1, 0, '0, '0, '0);
        cyc(0, 1, 56'hAB_CDEF_0123, 2'd1, 2'd2, 1, 1, 2'd1, 64'h1111_2222_3333_4444, 1'b0);
        chk("b2b_tag_switch", 64'(address_tag_o), 64'h00AB_CDEF_0);
        cyc(0, 0, '0, 2'd0, '0, 0, 1, 2'd2, 64'h5555_6666_7777_8888, 1'b1);
        idle_cyc();

        // Miss: response 40 cycles after grant
        cyc(0, 1, 56'h00_0000_4ABC, 2'd0, 2'd3, 1, 0, '0, '0, '0);
        repeat (39) idle_cyc();
        cyc(0, 0, '0, 2'd0, '0, 0, 1, 2'd3, 64'hCAFE_F00D_0000_0040, 1'b0);
        chk("miss_err", 64'(err_o), 64'd0);
        idle_cyc();

        // Flush in PEND with the response in the same cycle
        cyc(0, 1, 56'h00_0001_0000, 2'd3, 2'd0, 1, 0, '0, '0, '0);
        idle_cyc(); idle_cyc();
        cyc(1, 0, '0, 2'd0, '0, 0, 1, 2'd0, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
        idle_cyc();

        // Flush in PEND, response three cycles later; requests blocked while killing
        cyc(0, 1, 56'h00_0002_0000, 2'd3, 2'd2, 1, 0, '0, '0, '0);
        idle_cyc(); idle_cyc();
        cyc(1, 0, '0, 2'd0, '0, 0, 0, '0, '0, '0);
        cyc(0, 1, 56'h00_0003_0000, 2'd1, 2'd1, 1, 0, '0, '0, '0);
        cyc(0, 1, 56'h00_0003_0000, 2'd1, 2'd1, 1, 0, '0, '0, '0);
        cyc(0, 0, '0, 2'd0, '0, 0, 1, 2'd2, 64'hBAD1_BAD1_BAD1_BAD1, 1'b1);
        // Flush in IDLE just blocks the request
        cyc(1, 1, 56'h00_0004_0000, 2'd3, 2'd3, 1, 0, '0, '0, '0);
        idle_cyc();

        // Randomized legal traffic
        repeat (600) begin
            fl  = ($urandom_range(0, 9) == 0);
            opv = $urandom_range(0, 1) == 1;
            pa  = {$urandom, $urandom};
            rd  = {$urandom, $urandom};
            rv  = (m_alive || m_killed) && (($urandom_range(0, 2) == 0) || m_wd > 30);
            gnt = (!m_alive || rv) && ($urandom_range(0, 1) == 1);
            rid = m_alive ? m_id : IDW'($urandom);
            cyc(fl, opv, pa, 2'($urandom), IDW'($urandom), gnt, rv, rid, rd, UW'($urandom));
        end
        while (m_alive || m_killed)
            cyc(0, 0, '0, 2'd0, '0, 0, 1, m_id, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
        idle_cyc();

        // Response with nothing outstanding sets the sticky error
        cyc(0, 0, '0, 2'd0, '0, 0, 1, 2'd0, '0, '0);
        chk("idle_rvalid_err", 64'(err_o), 64'd1);
        idle_cyc();
        do_reset();

        // Watchdog: error after TO-1 pending cycles, sticky through the response
        cyc(0, 1, 56'h00_0005_0000, 2'd3, 2'd1, 1, 0, '0, '0, '0);
        repeat (TO - 2) idle_cyc();
        chk("wd_not_yet", 64'(err_o), 64'd0);
        idle_cyc();
        chk("wd_fired", 64'(err_o), 64'd1);
        repeat (3) idle_cyc();
        cyc(0, 0, '0, 2'd0, '0, 0, 1, 2'd1, 64'h0000_0000_0000_00AA, 1'b0);
        idle_cyc();
        chk("wd_sticky", 64'(err_o), 64'd1);
        do_reset();

        // Async reset while pending, then a normal load
        cyc(0, 1, 56'h00_0006_0000, 2'd3, 2'd2, 1, 0, '0, '0, '0);
        idle_cyc();
        do_reset();
        cyc(0, 1, 56'h7F_FFFF_FFFF, 2'd3, 2'd3, 1, 0, '0, '0, '0);
        cyc(0, 0, '0, 2'd0, '0, 0, 1, 2'd3, 64'h0123_4567_89AB_CDEF, 1'b1);
        idle_cyc();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
